// File: rtl/wb_bram_arb_pkg.sv
// Shared types and constants for the two-master Wishbone BRAM arbiter.
// Also read by the optional watchdog (WB_BRAM_ARB_TIMEOUT_EN).
package wb_bram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int TIMEOUT_CYCLES_DEF = 16;

  function automatic arb_state_e gnt_of(input logic m);
    return (m == M1) ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stalled-slave watchdog: counts un-acked strobe cycles and issues a one-cycle
// err pulse to the master that held the grant. Used only with WB_BRAM_ARB_TIMEOUT_EN.
module wb_arb_watchdog
  import wb_bram_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic idle_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic gnt_m_i,
  output logic fire_o,
  output logic err0_o,
  output logic err1_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             err_m_q, err_m_d;

  // fire is combinational so the arbiter drops the grant on the same edge
  // that registers the err pulse; the pulse therefore lands in the IDLE cycle.
  assign fire_o = stb_i & ~ack_i & (tmo_q == TMO_LAST);

  always_comb begin
    tmo_d   = tmo_q;
    err_d   = fire_o;
    err_m_d = err_m_q;
    if (idle_i || ack_i || fire_o) begin
      tmo_d = '0;
    end else if (stb_i) begin
      tmo_d = tmo_q + 1'b1;
    end
    if (fire_o) begin
      err_m_d = gnt_m_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_q   <= '0;
      err_q   <= 1'b0;
      err_m_q <= M0;
    end else begin
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      err_m_q <= err_m_d;
    end
  end

  assign err0_o = err_q & (err_m_q == M0);
  assign err1_o = err_q & (err_m_q == M1);

endmodule

// File: rtl/wb_bram_arb.sv
// Round-robin, cyc-locked arbiter sharing one Wishbone BRAM slave between two
// masters. Optional stall watchdog enabled by defining WB_BRAM_ARB_TIMEOUT_EN.
module wb_bram_arb
  import wb_bram_arb_pkg::*;
#(
  parameter int ADR_W          = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [31:0]      m0_dat_i,
  input  logic [3:0]       m0_sel_i,
  output logic [31:0]      m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [31:0]      m1_dat_i,
  input  logic [3:0]       m1_sel_i,
  output logic [31:0]      m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [31:0]      s_dat_o,
  output logic [3:0]       s_sel_o,
  input  logic [31:0]      s_dat_i,
  input  logic             s_ack_i
);

  // Handshake: a master requests with cyc&stb; each transfer completes on the
  // cycle ack is high with stb still high. Grant is held while the granted cyc
  // stays high, so a master may stream back-to-back strobes without stalls.

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wb_bram_arb: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e state_q, state_d;
  logic       prio_q, prio_d;
  logic       req0, req1;
  logic       tmo_fire;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      prio_q  <= M0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = gnt_of(prio_q);
        end else if (req0) begin
          state_d = GNT0;
        end else if (req1) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (tmo_fire) begin
          state_d = IDLE;
          prio_d  = M1;
        end else if (!m0_cyc_i) begin
          state_d = req1 ? GNT1 : IDLE;
          prio_d  = M1;
        end
      end
      GNT1: begin
        if (tmo_fire) begin
          state_d = IDLE;
          prio_d  = M0;
        end else if (!m1_cyc_i) begin
          state_d = req0 ? GNT0 : IDLE;
          prio_d  = M0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    case (state_q)
      GNT0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
      end
      default: begin
      end
    endcase
  end

  // Read data is broadcast; only the granted master ever sees ack.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & s_stb_o & (state_q == GNT0);
  assign m1_ack_o = s_ack_i & s_stb_o & (state_q == GNT1);

`ifdef WB_BRAM_ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .idle_i (state_q == IDLE),
    .stb_i  (s_stb_o),
    .ack_i  (s_ack_i),
    .gnt_m_i((state_q == GNT1) ? M1 : M0),
    .fire_o (tmo_fire),
    .err0_o (m0_err_o),
    .err1_o (m1_err_o)
  );
`else
  assign tmo_fire = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

endmodule
